// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order RV32I pipeline: tracks in-flight
// writers past Decode and produces decode stall, EXE1 forwarding selects, redirect flush and fence drain.
module pipe_hazard_ctrl #(
  parameter int  REG_AW          = 5,
  parameter int  PIPE_DEPTH      = 4,
  parameter int  ALU_READY_SLOT  = 2,
  parameter int  LOAD_READY_SLOT = 4,
  parameter int  FWD_EN          = 1,
  parameter int  FLUSH_BUBBLES   = 1,
  localparam int SW              = $clog2(PIPE_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_reg_wr,
  input  logic              dec_is_load,
  input  logic              dec_fence,
  input  logic              exe_redirect,
  output logic              stall,
  output logic              flush,
  output logic [SW-1:0]     fwd_rs1_sel,
  output logic [SW-1:0]     fwd_rs2_sel,
  output logic              busy,
  output logic [31:0]       stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic              reg_wr;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } slot_t;

  typedef struct packed {
    logic          stall;
    logic [SW-1:0] sel;
  } fwd_t;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FLUSH} state_e;

  state_e               state_q, state_d;
  logic [2:0]           flush_cnt_q, flush_cnt_d;
  slot_t [PIPE_DEPTH:1] slot_q;
  slot_t                dec_slot;
  logic [SW-1:0]        fwd_rs1_sel_q, fwd_rs2_sel_q;
  logic [31:0]          stall_cnt_q;
  logic                 any_valid, run_like, issue;
  fwd_t                 fwd1, fwd2;

  // Youngest matching writer decides; a writer in the last slot retires this
  // cycle and the regfile is write-before-read, so it needs neither stall nor forward.
  function automatic fwd_t resolve(input logic [REG_AW-1:0] r, input slot_t [PIPE_DEPTH:1] s);
    fwd_t res;
    logic found;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      if (!found && r != '0 && s[k].valid && s[k].reg_wr && s[k].rd == r) begin
        found = 1'b1;
        if (k < PIPE_DEPTH) begin
          if (FWD_EN == 0) res.stall = 1'b1;
          else if (k + 1 >= (s[k].is_load ? LOAD_READY_SLOT : ALU_READY_SLOT)) res.sel = SW'(k + 1);
          else res.stall = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++) any_valid = any_valid | slot_q[k].valid;
    dec_slot = '{valid: 1'b1, reg_wr: dec_reg_wr, is_load: dec_is_load, rd: dec_rd};
  end

  assign fwd1 = resolve(dec_rs1, slot_q);
  assign fwd2 = resolve(dec_rs2, slot_q);

  // NOTE: non-blocking assignments so all state updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (exe_redirect) begin
      state_d     = S_FLUSH;
      flush_cnt_d = 3'(FLUSH_BUBBLES);
    end else begin
      case (state_q)
        S_RUN:   if (dec_valid && dec_fence && any_valid) state_d = S_DRAIN;
        S_DRAIN: if (!any_valid) state_d = S_RUN;
        S_FLUSH: begin
          flush_cnt_d = flush_cnt_q - 3'd1;
          if (flush_cnt_q <= 3'd1) state_d = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // The drain ends on the cycle the scoreboard is empty: Decode is released then
  // and the held fence lands in slot 1 on the following cycle.
  always_comb begin
    run_like = (state_q == S_RUN) || (state_q == S_DRAIN && !any_valid);
    stall    = 1'b0;
    if (!rst && !exe_redirect) begin
      if (state_q == S_DRAIN && any_valid) stall = 1'b1;
      else if (run_like && dec_valid && ((dec_fence && any_valid) || fwd1.stall || fwd2.stall))
        stall = 1'b1;
    end
    issue = !rst && !exe_redirect && run_like && dec_valid && !stall;
    flush = !rst && exe_redirect;
    busy  = !rst && any_valid;
  end

  // NOTE: the scoreboard is tiny and must come up all-invalid, so it is reset whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q        <= '0;
      fwd_rs1_sel_q <= '0;
      fwd_rs2_sel_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      slot_q[1] <= issue ? dec_slot : slot_t'('0);
      for (int k = 2; k <= PIPE_DEPTH; k++) slot_q[k] <= slot_q[k-1];
      fwd_rs1_sel_q <= issue ? fwd1.sel : '0;
      fwd_rs2_sel_q <= issue ? fwd2.sel : '0;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fwd_rs1_sel = fwd_rs1_sel_q;
  assign fwd_rs2_sel = fwd_rs2_sel_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, checked each
// cycle against a timestamp-based model of the in-flight instructions.
module tb_pipe_hazard_ctrl;
  localparam int D  = 4;
  localparam int AR = 2;
  localparam int LR = 4;
  localparam int FB = 1;

  logic        clk = 1'b0;
  logic        rst, dec_valid, dec_reg_wr, dec_is_load, dec_fence, exe_redirect;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        stall, flush, busy;
  logic [2:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cnt;
  logic        nf_stall, nf_flush, nf_busy;
  logic [2:0]  nf_rs1_sel, nf_rs2_sel;
  logic [31:0] nf_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_ctrl #(.FWD_EN(1)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_reg_wr(dec_reg_wr), .dec_is_load(dec_is_load), .dec_fence(dec_fence),
    .exe_redirect(exe_redirect), .stall(stall), .flush(flush), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_sel(fwd_rs2_sel), .busy(busy), .stall_cnt(stall_cnt));

  pipe_hazard_ctrl #(.FWD_EN(0)) dut_nf (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_reg_wr(dec_reg_wr), .dec_is_load(dec_is_load), .dec_fence(dec_fence),
    .exe_redirect(exe_redirect), .stall(nf_stall), .flush(nf_flush), .fwd_rs1_sel(nf_rs1_sel),
    .fwd_rs2_sel(nf_rs2_sel), .busy(nf_busy), .stall_cnt(nf_stall_cnt));

  always #5 clk = ~clk;

  // Reference model: each accepted instruction is stamped with its decode cycle;
  // its pipeline position is simply the elapsed cycle count.
  typedef struct {
    logic [4:0] rd;
    bit         wr;
    bit         ld;
    int         t;
  } inst_t;

  inst_t  live[$];
  int     now = 0;
  bit     draining = 0;
  int     ignore_left = 0;
  int     m_sel1 = 0, m_sel2 = 0, m_nsel1 = 0, m_nsel2 = 0;
  longint m_cnt = 0;
  bit     known = 0;
  bit     m_stall, m_flush, m_busy, m_issue;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void hazard(input logic [4:0] r, output bit stl, output int sel);
    int best_age;
    bit best_ld;
    best_age = D + 1;
    best_ld  = 0;
    stl = 0;
    sel = 0;
    if (r == 5'd0) return;
    foreach (live[i]) begin
      if ((now - live[i].t) >= 1 && (now - live[i].t) <= D && live[i].wr && live[i].rd == r &&
          (now - live[i].t) < best_age) begin
        best_age = now - live[i].t;
        best_ld  = live[i].ld;
      end
    end
    if (best_age >= D) return;
    if (best_age + 1 >= (best_ld ? LR : AR)) sel = best_age + 1;
    else stl = 1;
  endfunction

  function automatic void model_eval();
    bit s1, s2;
    int q1, q2;
    m_busy = 0;
    foreach (live[i]) if ((now - live[i].t) >= 1 && (now - live[i].t) <= D) m_busy = 1;
    m_stall = 0; m_flush = 0; m_issue = 0; m_nsel1 = 0; m_nsel2 = 0;
    if (rst) begin
      m_busy = 0;
      return;
    end
    m_flush = exe_redirect;
    if (exe_redirect || ignore_left > 0) return;
    if (draining && m_busy) begin
      m_stall = 1;
      return;
    end
    if (!dec_valid) return;
    hazard(dec_rs1, s1, q1);
    hazard(dec_rs2, s2, q2);
    m_stall = (dec_fence && m_busy) || s1 || s2;
    m_issue = !m_stall;
    if (m_issue) begin
      m_nsel1 = q1;
      m_nsel2 = q2;
    end
  endfunction

  function automatic void model_commit();
    inst_t e;
    if (rst) begin
      live.delete();
      draining = 0; ignore_left = 0; m_sel1 = 0; m_sel2 = 0; m_cnt = 0; known = 1;
    end else begin
      if (m_stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_sel1 = m_nsel1;
      m_sel2 = m_nsel2;
      if (m_issue) begin
        e.rd = dec_rd; e.wr = dec_reg_wr; e.ld = dec_is_load; e.t = now;
        live.push_back(e);
      end
      if (exe_redirect) begin
        ignore_left = FB;
        draining    = 0;
      end else if (ignore_left > 0) ignore_left--;
      else if (draining) begin
        if (!m_busy) draining = 0;
      end else if (dec_valid && dec_fence && m_busy) draining = 1;
    end
    now++;
    for (int i = live.size() - 1; i >= 0; i--) if (now - live[i].t > D) live.delete(i);
  endfunction

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic ld,
                       input logic fn, input logic rdr);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
    dec_reg_wr = wr; dec_is_load = ld; dec_fence = fn; exe_redirect = rdr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    #1;
    model_eval();
    check("stall", 32'(stall), 32'(m_stall));
    check("flush", 32'(flush), 32'(m_flush));
    check("busy", 32'(busy), 32'(m_busy));
    if (known) begin
      check("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(m_sel1));
      check("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(m_sel2));
      check("stall_cnt", stall_cnt, 32'(m_cnt));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle();
    repeat (n) begin
      settle();
      advance();
    end
    rst = 1'b0;
  endtask

  // Presents one instruction and holds it until accepted; returns DUT stall cycles.
  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wr, input logic ld, input logic fn, output int n);
    int guard;
    guard = 0;
    n = 0;
    drive(1'b1, rs1, rs2, rd, wr, ld, fn, 1'b0);
    settle();
    while (m_stall && guard < 20) begin
      if (stall) n++;
      guard++;
      advance();
      settle();
    end
    check("send_bound", 32'(m_stall), 32'd0);
    advance();
  endtask

  initial begin
    int n, dut_st, nf_st;

    // Reset state
    do_reset(2);
    idle();
    settle();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel1", 32'(fwd_rs1_sel), 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    advance();

    // ALU result forwarded back-to-back
    send(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, n);
    send(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, n);
    check("alu_b2b_stall", 32'(n), 32'd0);
    idle();
    settle();
    check("alu_b2b_sel", 32'(fwd_rs1_sel), 32'd2);
    advance();

    // Load-use, with and without forwarding
    do_reset(1);
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    advance();
    drive(1'b1, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    dut_st = 0;
    nf_st  = 0;
    for (int c = 1; c <= 5; c++) begin
      settle();
      if (c <= 3 && stall) dut_st++;
      if (nf_stall) nf_st++;
      check("nf_sel1", 32'(nf_rs1_sel), 32'd0);
      check("nf_sel2", 32'(nf_rs2_sel), 32'd0);
      check("nf_flush", 32'(nf_flush), 32'd0);
      if (c == 1) check("nf_busy", 32'(nf_busy), 32'd1);
      if (c == 4) begin
        check("ld_use_sel1", 32'(fwd_rs1_sel), 32'd4);
        check("ld_use_sel2", 32'(fwd_rs2_sel), 32'd4);
        check("ld_use_cnt", stall_cnt, 32'd2);
      end
      advance();
    end
    check("ld_use_stalls", 32'(dut_st), 32'd2);
    check("nf_ld_use_stalls", 32'(nf_st), 32'd3);
    check("nf_ld_use_cnt", nf_stall_cnt, 32'd3);

    // x0 never matches; youngest writer wins
    do_reset(1);
    send(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, n);
    check("x0_stall", 32'(n), 32'd0);
    idle();
    settle();
    check("x0_sel", 32'(fwd_rs1_sel), 32'd0);
    advance();
    send(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, n);
    send(5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, n);
    check("youngest_stall", 32'(n), 32'd0);
    idle();
    settle();
    check("youngest_sel", 32'(fwd_rs1_sel), 32'd2);
    advance();

    // Redirect beats a pending stall; the following decode slot is ignored
    do_reset(1);
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    advance();
    drive(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    check("redir_flush", 32'(flush), 32'd1);
    check("redir_stall", 32'(stall), 32'd0);
    advance();
    drive(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("flush_ignore_stall", 32'(stall), 32'd0);
    advance();
    drive(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check("after_flush_stall", 32'(stall), 32'd0);
    advance();
    idle();
    settle();
    check("killed_not_fwd", 32'(fwd_rs1_sel), 32'd0);
    advance();

    // Fence drain with slots 2..4 occupied
    do_reset(1);
    send(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, n);
    idle();
    settle();
    advance();
    send(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, n);
    check("drain_stalls", 32'(n), 32'd3);
    idle();
    settle();
    check("fence_in_slot1", 32'(busy), 32'd1);
    advance();

    // Reset in the middle of a drain
    do_reset(1);
    send(5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0, n);
    send(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, n);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check("drain_enter", 32'(stall), 32'd1);
    advance();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    idle();
    settle();
    check("drain_rst_busy", 32'(busy), 32'd0);
    check("drain_rst_stall", 32'(stall), 32'd0);
    advance();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    check("fence_idle_stall", 32'(stall), 32'd0);
    advance();

    // Stall counter saturation from a preloaded value
    do_reset(1);
    force dut.stall_cnt_q = 32'hFFFF_FFFB;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 64'hFFFF_FFFB;
    for (int i = 0; i < 3; i++) begin
      send(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, n);
      send(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, n);
    end
    idle();
    settle();
    check("cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
    advance();

    // Random traffic on a small register set to provoke hazards
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
      settle();
      advance();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
